// File: rtl/mmio_console_pkg.sv
// Shared types and register map for the memory-mapped debug console.
package mmio_console_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } console_state_e;

  localparam logic [1:0] CONSOLE_EXIT    = 2'd0;
  localparam logic [1:0] CONSOLE_TXDATA  = 2'd1;
  localparam logic [1:0] CONSOLE_STATUS  = 2'd2;
  localparam logic [1:0] CONSOLE_SCRATCH = 2'd3;

  localparam int CONSOLE_OVF_BIT = 16;

endpackage

// File: rtl/mmio_console_if.sv
// Data-bus access plus the outgoing character stream of the console.
interface mmio_console_if #(parameter int ADDR_WIDTH = 16);

  logic                  en_i;
  logic [3:0]            we_i;
  logic [ADDR_WIDTH-1:0] addr_i;
  logic [31:0]           data_i;
  logic [31:0]           data_o;
  logic [7:0]            char_o;
  logic                  char_valid_o;
  logic                  char_ready_i;

  modport master (
    output en_i, we_i, addr_i, data_i, char_ready_i,
    input  data_o, char_o, char_valid_o
  );

  modport slave (
    input  en_i, we_i, addr_i, data_i, char_ready_i,
    output data_o, char_o, char_valid_o
  );

endinterface

// File: rtl/mmio_console_fifo.sv
// Synchronous byte FIFO; a push into a full FIFO is accepted when a pop frees the slot the same cycle.
module mmio_fifo #(
  parameter  int DEPTH = 16,
  parameter  int WIDTH = 8,
  localparam int LVL_W = $clog2(DEPTH) + 1,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [LVL_W-1:0] wr_cnt;
  logic [LVL_W-1:0] rd_cnt;
  logic             do_push;
  logic             do_pop;

  assign level   = wr_cnt - rd_cnt;
  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // Head is forced to zero when empty so stale storage never leaks out.
  assign dout    = empty ? '0 : mem[rd_cnt[PTR_W-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
    end else begin
      if (do_push) wr_cnt <= wr_cnt + LVL_W'(1);
      if (do_pop)  rd_cnt <= rd_cnt + LVL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_cnt[PTR_W-1:0]] <= din;
  end

endmodule

// File: rtl/mmio_console.sv
// Debug console / simulation-control peripheral: TX FIFO, exit-code halt sequencing, status and scratch.
//   state | meaning
//   RUN   | normal operation, characters queued and drained
//   DRAIN | exit code latched, waiting for the FIFO to run dry
//   HALT  | drained; halt_o high, writes ignored until reset
module mmio_console
  import mmio_console_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  mmio_console_if.slave        bus,
  output logic [7:0]           exit_code_o,
  output logic                 halt_o
);

  localparam int LVL_W = $clog2(DEPTH) + 1;

  console_state_e   state;
  logic [1:0]       reg_sel;
  logic             rd_en, wr_en;
  logic             exit_wr, tx_wr, ovf_clr;
  logic             pop, push_acc;
  logic             full, empty;
  logic [LVL_W-1:0] level, level_nxt;
  logic             drained;
  logic             overflow;
  logic [31:0]      scratch;
  logic [31:0]      rd_mux;
  logic [31:0]      rd_data_q;
  logic             unused_addr;

  assign unused_addr = ^{bus.addr_i[ADDR_WIDTH-1:4], bus.addr_i[1:0]};

  assign reg_sel  = bus.addr_i[3:2];
  assign rd_en    = bus.en_i && (bus.we_i == 4'b0000);
  assign wr_en    = bus.en_i && (bus.we_i != 4'b0000) && (state != HALT);
  assign exit_wr  = wr_en && (reg_sel == CONSOLE_EXIT) && bus.we_i[0];
  assign tx_wr    = wr_en && (reg_sel == CONSOLE_TXDATA) && bus.we_i[0];
  assign ovf_clr  = wr_en && (reg_sel == CONSOLE_STATUS) && bus.we_i[2] && bus.data_i[CONSOLE_OVF_BIT];
  assign pop      = bus.char_valid_o && bus.char_ready_i;
  assign push_acc = tx_wr && (!full || pop);
  assign level_nxt = level + LVL_W'(push_acc) - LVL_W'(pop);

  mmio_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (tx_wr),
    .pop     (pop),
    .din     (bus.data_i[7:0]),
    .dout    (bus.char_o),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

  assign bus.char_valid_o = !empty;
  assign bus.data_o       = rd_data_q;

  always_comb begin
    rd_mux = '0;
    case (reg_sel)
      CONSOLE_EXIT:    rd_mux = {24'h0, exit_code_o};
      CONSOLE_TXDATA:  rd_mux = '0;
      CONSOLE_STATUS:  rd_mux = {15'h0, overflow, 6'h0, full, empty, 8'(level)};
      CONSOLE_SCRATCH: rd_mux = scratch;
      default:         rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= RUN;
      halt_o      <= 1'b0;
      drained     <= 1'b0;
      exit_code_o <= '0;
      overflow    <= 1'b0;
      scratch     <= '0;
      rd_data_q   <= '0;
    end else begin
      rd_data_q <= rd_en ? rd_mux : '0;
      if (exit_wr) exit_code_o <= bus.data_i[7:0];
      if (tx_wr && full && !pop) overflow <= 1'b1;
      else if (ovf_clr)          overflow <= 1'b0;
      if (wr_en && (reg_sel == CONSOLE_SCRATCH)) begin
        for (int i = 0; i < 4; i++) begin
          if (bus.we_i[i]) scratch[8*i +: 8] <= bus.data_i[8*i +: 8];
        end
      end
      // drained marks "FIFO became empty this edge while draining"; HALT follows one edge later.
      drained <= (state == DRAIN) && (level_nxt == '0) && !tx_wr;
      case (state)
        RUN:   if (exit_wr) state <= DRAIN;
        DRAIN: if (drained && !tx_wr) begin
                 state  <= HALT;
                 halt_o <= 1'b1;
               end
        HALT:  state <= HALT;
        default: state <= RUN;
      endcase
    end
  end

endmodule
